sub_serial_ctrl: RTL and testbench
==================================

Name: sub_serial_ctrl

Overview:
- Sequencer that performs WIDTH-bit subtraction A − B − bin on a single shared 4-bit ripple-borrow subtractor stage, one nibble per clock, LSB nibble first.
- The borrow is registered between nibbles.
- Sits between switch/operand logic and the 7-seg/BCD display path, so wide differences are produced without instantiating WIDTH/4 subtractor slices.
- Start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥4.
- NIBBLES, WIDTH/4, derived; not to be overridden.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; captured on accepted start.
- b  in  WIDTH  subtrahend; captured on accepted start.
- bin  in  1  borrow-in to nibble 0; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- diff  out  WIDTH  result; registered, held between operations.
- borrow  out  1  final borrow-out of the MSB nibble; registered, held.

Behaviour:
- Reset (reset_n low at a rising edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0.
  - Internal operand, work and index registers cleared.
  - An operation in progress is aborted; no done pulse is produced.
- States: IDLE, RUN, DONE (2-bit encoding). busy = (state≠IDLE); done = (state==DONE).
- IDLE:
  - start=1 at an edge: capture a→a_r, b→b_r, bin→brw_r; idx=0; work=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Nibble stage computes {bo, d} from a_r[idx], b_r[idx], brw_r.
  - work[idx] ← d; brw_r ← bo; idx ← idx+1.
  - When idx==NIBBLES−1 at the edge: diff ← work with the final nibble merged in, borrow ← bo, go to DONE.
- DONE: one cycle only, then unconditionally to IDLE.
- Latency:
  - Start sampled at edge k → done high for the cycle following edge k+NIBBLES.
  - WIDTH=16: done high after the 4th edge following the start edge.
  - WIDTH=4: single RUN cycle.
- Throughput: one operation per NIBBLES+2 cycles. start is ignored in RUN and DONE; there is no queueing. start held high re-triggers on the first IDLE edge.
- diff/borrow change only on the RUN→DONE edge. They hold through IDLE and the next RUN and are never partially updated.
- Arithmetic:
  - Per-nibble: d = x XOR y XOR bi; bo = (~x & (y|bi)) | (x & y & bi).
  - Result equals (a − b − bin) mod 2^WIDTH; borrow=1 iff a < b+bin (unsigned).
- idx width: max(1, clog2(NIBBLES)). idx never wraps past NIBBLES−1.
- a/b/bin changes after capture have no effect on the running operation.
- Simultaneous reset_n low and start high: reset wins.

Optional Feature:
- SUB_SERIAL_SATURATE_EN defined: at the RUN→DONE edge, if the final bo=1, diff ← 0 (clamp at zero) and borrow ← 1.
- Not defined: diff is the wrapped modulo result. All other behaviour and timing are identical.

Decomposition:
- Package sub_serial_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - NIBBLE_W=4.
- Sub-module sub_nibble_stage: combinational 4-bit ripple-borrow subtractor.
  - Ports: x[3:0], y[3:0], bin → dif[3:0], bor.
  - Built from per-bit borrow equations.
  - Instantiated exactly once in the controller.

Test Plan:
- WIDTH=16: a=16'h1234, b=16'h0235, bin=0, start pulse → busy for 5 cycles, done pulse on the cycle after edge 4, diff=16'h0FFF, borrow=0.
- Full borrow chain: a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, borrow=1. With SUB_SERIAL_SATURATE_EN: diff=16'h0000, borrow=1.
- Borrow-in: a=16'h8000, b=16'h7FFF, bin=1 → diff=16'h0000, borrow=0. Change a to 16'hFFFF one cycle after start → result unchanged.
- start held high continuously → operations accepted every 6 cycles. Previous diff is stable during RUN until each new RUN→DONE edge.
- reset_n low for one edge during the 2nd RUN cycle → IDLE, diff=0, borrow=0, busy=0, no done pulse. The next start completes correctly.
- WIDTH=4 instance: a=4'h3, b=4'h5, bin=0 → done after 1 RUN edge, diff=4'hE, borrow=1.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding
// and the width of the single shared subtractor slice.
package sub_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_nibble_stage.sv
// Combinational 4-bit ripple-borrow subtractor: {bor, dif} = x - y - bin.
// Built bit by bit from the full-subtractor borrow equation.
module sub_nibble_stage
  import sub_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] dif,
  output logic                bor
);

  // Ripple the borrow from bit 0 upward, producing one difference bit per step
  always_comb begin : p_ripple
    logic [NIBBLE_W:0] c;
    c    = '0;
    dif  = '0;
    c[0] = bin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      dif[i]  = x[i] ^ y[i] ^ c[i];
      c[i+1]  = (~x[i] & (y[i] | c[i])) | (x[i] & y[i] & c[i]);
    end
    bor = c[NIBBLE_W];
  end

endmodule

// File: rtl/sub_serial_ctrl.sv
// Nibble-serial WIDTH-bit subtractor: diff = a - b - bin computed one nibble
// per clock on a single shared 4-bit stage, LSB nibble first, with the borrow
// registered between nibbles. start/busy/done handshake.
// Optional build macro SUB_SERIAL_SATURATE_EN: when defined, a final borrow
// clamps diff to zero (borrow still reports 1); otherwise diff wraps modulo
// 2^WIDTH.
module sub_serial_ctrl
  import sub_serial_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / NIBBLE_W
)(
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_work;
  logic [WIDTH-1:0]    r_diff;
  logic                r_brw;
  logic                r_borrow;
  logic [IDX_W-1:0]    r_idx;

  logic [NIBBLE_W-1:0] w_x;
  logic [NIBBLE_W-1:0] w_y;
  logic [NIBBLE_W-1:0] w_d;
  logic                w_bo;
  logic                w_last;
  logic [WIDTH-1:0]    w_merged;
  logic [WIDTH-1:0]    w_result;

  assign w_last = (r_idx == IDX_LAST);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;

  // Select the operand nibbles addressed by the current index
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_x = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_y = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  sub_nibble_stage u_stage (
    .x   (w_x),
    .y   (w_y),
    .bin (r_brw),
    .dif (w_d),
    .bor (w_bo)
  );

  // Merge this cycle's difference nibble into the partial result
  always_comb begin
    w_merged = r_work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_merged[i*NIBBLE_W +: NIBBLE_W] = w_d;
      end
    end
  end

  // Final value published on the RUN->DONE edge
  always_comb begin
    w_result = w_merged;
`ifdef SUB_SERIAL_SATURATE_EN
    if (w_bo) begin
      w_result = '0;
    end
`endif
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle; start only seen in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and result publication
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_brw    <= 1'b0;
      r_work   <= '0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_brw  <= bin;
            r_idx  <= '0;
            r_work <= '0;
          end
        end
        S_RUN: begin
          r_work <= w_merged;
          r_brw  <= w_bo;
          if (w_last) begin
            r_diff   <= w_result;
            r_borrow <= w_bo;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Self-checking bench for sub_serial_ctrl: a WIDTH=16 and a WIDTH=4 instance,
// expected results queued at start and compared when done pulses.
module tb_sub_serial_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start16, bin16, busy16, done16, borrow16;
  logic [15:0] a16, b16, diff16;

  logic        start4, bin4, busy4, done4, borrow4;
  logic [3:0]  a4, b4, diff4;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] last_diff16;

  sub_serial_ctrl #(.WIDTH(16)) dut16 (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .start    (start16),
    .a        (a16),
    .b        (b16),
    .bin      (bin16),
    .busy     (busy16),
    .done     (done16),
    .diff     (diff16),
    .borrow   (borrow16)
  );

  sub_serial_ctrl #(.WIDTH(4)) dut4 (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .bin      (bin4),
    .busy     (busy4),
    .done     (done4),
    .diff     (diff4),
    .borrow   (borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    logic [16:0] r;
    r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
`ifdef SUB_SERIAL_SATURATE_EN
    if (r[16]) r[15:0] = '0;
`endif
    return r;
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y,
                                        input logic bi);
    logic [4:0] r;
    r = {1'b0, x} - {1'b0, y} - {4'd0, bi};
`ifdef SUB_SERIAL_SATURATE_EN
    if (r[4]) r[3:0] = '0;
`endif
    return r;
  endfunction

  // Scoreboard: compare each done pulse against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) chk("spurious_done16", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = q16.pop_front();
        chk("diff16", 32'(diff16), 32'(e[15:0]));
        chk("borrow16", 32'(borrow16), 32'(e[16]));
      end
    end
    if (rst_n && done4) begin
      if (q4.size() == 0) chk("spurious_done4", 32'd1, 32'd0);
      else begin
        logic [4:0] e4;
        e4 = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e4[3:0]));
        chk("borrow4", 32'(borrow4), 32'(e4[4]));
      end
    end
  end

  // One 16-bit operation: drive at a negedge, follow it for six cycles.
  // hold keeps start high (back-to-back); chg_a alters a after capture.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin, input bit hold, input bit chg_a);
    logic [16:0] e;
    a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
    e = model16(ta, tb, tbin);
    q16.push_back(e);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold) start16 = 1'b0;
        if (chg_a) a16 = 16'hFFFF;
      end
      chk($sformatf("busy16_c%0d", n), 32'(busy16), (n <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("done16_c%0d", n), 32'(done16), (n == 5) ? 32'd1 : 32'd0);
      if (n <= 4) chk($sformatf("diff16_hold_c%0d", n), 32'(diff16), 32'(last_diff16));
    end
    last_diff16 = e[15:0];
  endtask

  initial begin
    rst_n = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; bin4  = 1'b0;
    last_diff16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_diff16", 32'(diff16), 32'd0);
    chk("rst_borrow16", 32'(borrow16), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_diff4", 32'(diff4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, full borrow chain, borrow-in with operand change after capture
    do_op16(16'h1234, 16'h0235, 1'b0, 1'b0, 1'b0);
    do_op16(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op16(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1);

    // start held high: accepted every six cycles
    do_op16(16'hABCD, 16'h1111, 1'b0, 1'b1, 1'b0);
    do_op16(16'h0100, 16'h0200, 1'b1, 1'b1, 1'b0);
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    start16 = 1'b0;
    @(negedge clk);

    // Reset during the second RUN cycle aborts without a done pulse
    a16 = 16'h5555; b16 = 16'h1234; bin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy16", 32'(busy16), 32'd0);
    chk("abort_done16", 32'(done16), 32'd0);
    chk("abort_diff16", 32'(diff16), 32'd0);
    chk("abort_borrow16", 32'(borrow16), 32'd0);
    last_diff16 = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_done16", 32'(done16), 32'd0);
    end
    do_op16(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Single-nibble instance: one RUN cycle
    a4 = 4'h3; b4 = 4'h5; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back(model4(4'h3, 4'h5, 1'b0));
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) start4 = 1'b0;
      chk($sformatf("busy4_c%0d", n), 32'(busy4), (n <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("done4_c%0d", n), 32'(done4), (n == 2) ? 32'd1 : 32'd0);
    end
    a4 = 4'hA; b4 = 4'h2; bin4 = 1'b1; start4 = 1'b1;
    q4.push_back(model4(4'hA, 4'h2, 1'b1));
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);

    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
